// File: rtl/irrigation_scheduler_if.sv
// Sensor/request inputs and actuator/status outputs of the irrigation scheduler.
interface irrigation_scheduler_if;
    logic       tick;
    logic       low_water_level;
    logic       mid_water_level;
    logic       high_water_level;
    logic       splinker_request;
    logic       dripper_request;
    logic       alarm_clear;
    logic       water_supply_valvule;
    logic       splinker_bomb;
    logic       dripper_valvule;
    logic       alarm;
    logic [2:0] state;

    modport master (
        output tick, low_water_level, mid_water_level, high_water_level,
               splinker_request, dripper_request, alarm_clear,
        input  water_supply_valvule, splinker_bomb, dripper_valvule, alarm, state
    );

    modport slave (
        input  tick, low_water_level, mid_water_level, high_water_level,
               splinker_request, dripper_request, alarm_clear,
        output water_supply_valvule, splinker_bomb, dripper_valvule, alarm, state
    );
endinterface

// File: rtl/irrigation_scheduler.sv
// Greenhouse irrigation controller: input debouncing, sticky alarm, tank fill
// hysteresis and round-robin pump sharing between sprinkler and dripper.
module irr_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (raw != filt) begin
            if (cnt == 4'(FILTER_CYCLES - 1)) begin
                filt <= raw;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end else begin
            cnt <= '0;
        end
    end
endmodule

module irrigation_scheduler #(
    parameter int FILTER_CYCLES = 4,
    parameter int MIN_ON_TICKS  = 8,
    parameter int MAX_RUN_TICKS = 60,
    parameter int MIN_OFF_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    irrigation_scheduler_if.slave bus
);
    localparam int NUM_IN = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SPRINKLE = 3'd1,
        DRIP     = 3'd2,
        REST     = 3'd3,
        FAULT    = 3'd4
    } state_t;

    logic [NUM_IN-1:0] raw_vec, flt_vec;
    logic low_f, mid_f, high_f, spr_f, drp_f;

    assign raw_vec = {bus.dripper_request, bus.splinker_request,
                      bus.high_water_level, bus.mid_water_level, bus.low_water_level};
    assign {drp_f, spr_f, high_f, mid_f, low_f} = flt_vec;

    irr_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_flt [NUM_IN-1:0] (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_vec),
        .filt (flt_vec)
    );

    state_t     st, st_nxt;
    logic [7:0] run_cnt, rest_cnt;
    logic       last_drip, last_drip_nxt;
    logic       alarm_q, alarm_nxt, timeout;
    logic       valve_q, valve_nxt;
    logic       bomb_q, drip_q;
    logic       level_err, own_req, in_run;

    assign level_err = (mid_f & ~low_f) | (high_f & (~mid_f | ~low_f));
    assign own_req   = (st == SPRINKLE) ? spr_f : drp_f;
    assign in_run    = (st == SPRINKLE) || (st == DRIP);

    // A fresh fault always wins over an operator clear in the same cycle.
    assign alarm_nxt = level_err | timeout | (alarm_q & ~bus.alarm_clear);

    always_comb begin
        if (alarm_nxt)    valve_nxt = 1'b0;
        else if (!low_f)  valve_nxt = 1'b1;
        else if (high_f)  valve_nxt = 1'b0;
        else              valve_nxt = valve_q;
    end

    always_comb begin
        st_nxt        = st;
        last_drip_nxt = last_drip;
        timeout       = 1'b0;
        unique case (st)
            IDLE: begin
                if (alarm_q) begin
                    st_nxt = FAULT;
                end else if (low_f && (spr_f || drp_f)) begin
                    if (spr_f && (!drp_f || last_drip)) begin
                        st_nxt        = SPRINKLE;
                        last_drip_nxt = 1'b0;
                    end else begin
                        st_nxt        = DRIP;
                        last_drip_nxt = 1'b1;
                    end
                end
            end
            SPRINKLE, DRIP: begin
                if (alarm_q) begin
                    st_nxt = FAULT;
                end else if (!low_f) begin
                    st_nxt = REST;
                end else if (run_cnt >= 8'(MAX_RUN_TICKS)) begin
                    timeout = 1'b1;
                    st_nxt  = REST;
                end else if (!own_req && run_cnt >= 8'(MIN_ON_TICKS)) begin
                    st_nxt = REST;
                end
            end
            REST: begin
                if (alarm_q)                              st_nxt = FAULT;
                else if (rest_cnt >= 8'(MIN_OFF_TICKS))   st_nxt = IDLE;
            end
            FAULT: begin
                // Leave on the same edge the alarm drops; rest time still applies.
                if (!level_err && (bus.alarm_clear || !alarm_q)) st_nxt = REST;
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            last_drip <= 1'b1;
            alarm_q   <= 1'b0;
            valve_q   <= 1'b0;
            bomb_q    <= 1'b0;
            drip_q    <= 1'b0;
            run_cnt   <= '0;
            rest_cnt  <= '0;
        end else begin
            st        <= st_nxt;
            last_drip <= last_drip_nxt;
            alarm_q   <= alarm_nxt;
            valve_q   <= valve_nxt;
            bomb_q    <= (st_nxt == SPRINKLE);
            drip_q    <= (st_nxt == DRIP);

            if (st_nxt != st)
                run_cnt <= '0;
            else if (in_run && bus.tick && run_cnt != 8'hFF)
                run_cnt <= run_cnt + 8'd1;

            if (st_nxt != st)
                rest_cnt <= '0;
            else if (st == REST && bus.tick && rest_cnt != 8'hFF)
                rest_cnt <= rest_cnt + 8'd1;
        end
    end

    assign bus.state                = st;
    assign bus.alarm                = alarm_q;
    assign bus.water_supply_valvule = valve_q;
    assign bus.splinker_bomb        = bomb_q;
    assign bus.dripper_valvule      = drip_q;
endmodule

// File: doc/irrigation_scheduler.md
# irrigation_scheduler

Sequential controller for the greenhouse irrigation system. It filters the raw tank-level and request inputs, latches sensor-fault alarms, and controls the tank fill valve with hysteresis. It also shares the single water pump between the sprinkler and the dripper with round-robin arbitration, enforcing minimum run, maximum run and rest times. It sits between the combinational sprinkler/dripper request logic and the physical actuators.

## Interface
- FILTER_CYCLES, 4: consecutive identical samples needed before a filtered input changes (1..15)
- MIN_ON_TICKS, 8: minimum irrigation run length in ticks (1..255)
- MAX_RUN_TICKS, 60: irrigation timeout in ticks (≥ MIN_ON_TICKS, ≤ 255)
- MIN_OFF_TICKS, 4: pump rest time in ticks between runs (1..255)
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high
- tick  in  1  one-cycle time-base pulse; all tick counters advance only on it
- low_water_level, mid_water_level, high_water_level  in  1 each  raw tank level sensors
- splinker_request, dripper_request  in  1 each  raw irrigation requests
- alarm_clear  in  1  operator clear of the latched alarm
- water_supply_valvule  out  1  tank fill valve
- splinker_bomb  out  1  sprinkler pump enable
- dripper_valvule  out  1  dripper valve
- alarm  out  1  latched sensor or timeout fault
- state  out  3  IDLE=0, SPRINKLE=1, DRIP=2, REST=3, FAULT=4

## Operation
- Filter: each of the 5 raw inputs has a 4-bit stability counter. The filtered value takes the raw value on the edge where the raw value has differed from the filtered value for FILTER_CYCLES consecutive samples. Any mismatch-free sample resets that input's counter.
- Level error: the filtered levels are inconsistent when mid=1 with low=0, or high=1 with mid=0 or low=0. An inconsistency sets alarm.
- Alarm is sticky. It clears only on an edge where alarm_clear=1 and the filtered levels are consistent. If set and clear coincide, set wins.
- Fill valve:
  - Opens when filtered low=0.
  - Closes when filtered high=1.
  - Otherwise holds its value.
  - Forced to 0 while alarm=1.
- Round-robin: the last_served flag resets to "dripper", so the sprinkler wins the first tie. When both requests are pending in IDLE, the requester not last served is granted. A single pending request is granted directly.
- IDLE → SPRINKLE/DRIP on a granted filtered request, only if filtered low=1 and alarm=0. The run counter clears on entry.
- SPRINKLE/DRIP, in priority order:
  - alarm → FAULT.
  - Filtered low=0 → REST, immediately, regardless of minimum on time.
  - Run counter reaches MAX_RUN_TICKS → set alarm and go to REST.
  - Own request is 0 and run counter ≥ MIN_ON_TICKS → REST.
- REST: counts MIN_OFF_TICKS ticks, then → IDLE. alarm → FAULT.
- FAULT: all actuators off. On the edge where alarm clears → REST. Rest time still applies.
- Any state: alarm → FAULT on the next edge.
- splinker_bomb=1 only in SPRINKLE; dripper_valvule=1 only in DRIP. The two are never simultaneously 1.

## Timing
- Reset values:
  - All outputs 0.
  - state=IDLE.
  - All filtered inputs 0; stability, run and rest counters 0.
  - last_served=dripper.
- Outputs are registers updated on the same edge as state. There is no combinational path from any input to any output.
- Input-to-filtered latency is FILTER_CYCLES edges. Filtered-to-actuator latency is 1 edge, for a total of FILTER_CYCLES+1 cycles from a raw change.
- Counters increment only on edges where tick=1. A tick in the same cycle as state entry is not counted.
- Run counter saturates at 255. Rest counter clears on REST entry.
- Reset asserted mid-run forces all outputs to 0 asynchronously. The next run after reset starts with a fresh filter, so there is no actuator activity for at least FILTER_CYCLES+1 cycles after release.

## Test plan
- Reset, low=mid=1, splinker_request=1 held 4 cycles → splinker_bomb=1 on cycle 5, state=1. Drop the request after 3 ticks → stays on until tick 8, then state=3. After 4 ticks → state=0.
- Both requests held continuously, MIN_ON_TICKS elapsed, requests toggled off then on → grants alternate SPRINKLE, DRIP, SPRINKLE. Outputs never both 1.
- During DRIP, low_water_level falls to 0 for 4 cycles → dripper_valvule=0 and water_supply_valvule=1 on the same edge. Valve stays 1 until high=1 filtered, then 0.
- high=1 with mid=0 for 4 cycles → alarm=1, state=4, all actuators 0. alarm_clear while still inconsistent → no change. Levels fixed, then clear → alarm=0, state=3.
- Sprinkler request held 60 ticks → alarm=1 at tick 60, state=3, then FAULT.
- 2-cycle glitch on dripper_request with FILTER_CYCLES=4 → no state change. reset pulse mid-SPRINKLE → splinker_bomb=0 with no clock edge.
